fifo_wr_sched: RTL and testbench

FIFO_WR_SCHED -- requirements
Module: fifo_wr_sched

---
 rtl/fifo_wr_sched_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 44 ++++
 rtl/fifo_wr_sched.sv | 108 ++++++++++
 tb/tb_fifo_wr_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_sched_pkg.sv
// fifo_wr_sched_pkg -- shared state encoding and widths for the FIFO write scheduler.
// Rev 1.0
`default_nettype none

package fifo_wr_sched_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int BYTE_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RF_BYTE = 2'd1,
        ST_ALU_LO  = 2'd2,
        ST_ALU_HI  = 2'd3
    } state_t;

    function automatic logic is_byte_state(state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester round-robin arbiter (RF vs ALU) with its priority flop.
// Rev 1.0
`default_nettype none

module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_rf,
    input  logic req_alu,
    output logic gnt_rf,
    output logic gnt_alu
);

    // alu_prio_q high means RF was granted last, so ALU wins a tie next time.
    logic alu_prio_q;
    logic alu_prio_d;

    always_comb begin
        gnt_rf     = 1'b0;
        gnt_alu    = 1'b0;
        alu_prio_d = alu_prio_q;
        if (en) begin
            if (req_rf && (!req_alu || !alu_prio_q)) begin
                gnt_rf     = 1'b1;
                alu_prio_d = 1'b1;
            end else if (req_alu) begin
                gnt_alu    = 1'b1;
                alu_prio_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_prio_q <= 1'b0;
        end else begin
            alu_prio_q <= alu_prio_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched -- serialises RF bytes and split ALU words into a FIFO write port.
// Rev 1.0
`default_nettype none

module fifo_wr_sched #(
    parameter int WIDTH = fifo_wr_sched_pkg::DEFAULT_WIDTH
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    RF_REQ,
    input  logic [WIDTH-1:0]                        RF_DATA,
    input  logic                                    ALU_REQ,
    input  logic [2*WIDTH-1:0]                      ALU_DATA,
    input  logic                                    FULL,
    output logic                                    RF_ACK,
    output logic                                    ALU_ACK,
    output logic                                    W_INC,
    output logic [WIDTH-1:0]                        WR_DATA,
    output logic [fifo_wr_sched_pkg::BYTE_CNT_W-1:0] BYTE_CNT,
    output logic                                    BUSY
);

    import fifo_wr_sched_pkg::*;

    state_t                  state_q, state_d;
    logic [2*WIDTH-1:0]      hold_q, hold_d;
    logic                    rf_ack_q, rf_ack_d;
    logic                    alu_ack_q, alu_ack_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    w_inc;
    logic [WIDTH-1:0]        wr_data;
    logic                    gnt_rf, gnt_alu;

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst_n   (RST),
        .en      (state_q == ST_IDLE),
        .req_rf  (RF_REQ),
        .req_alu (ALU_REQ),
        .gnt_rf  (gnt_rf),
        .gnt_alu (gnt_alu)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rf_ack_d  = 1'b0;
        alu_ack_d = 1'b0;
        wr_data   = '0;
        w_inc     = is_byte_state(state_q) && !FULL;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_rf) begin
                    hold_d   = {{WIDTH{1'b0}}, RF_DATA};
                    rf_ack_d = 1'b1;
                    state_d  = ST_RF_BYTE;
                end else if (gnt_alu) begin
                    hold_d    = ALU_DATA;
                    alu_ack_d = 1'b1;
                    state_d   = ST_ALU_LO;
                end
            end
            ST_RF_BYTE: begin
                wr_data = hold_q[WIDTH-1:0];
                if (w_inc) state_d = ST_IDLE;
            end
            ST_ALU_LO: begin
                wr_data = hold_q[WIDTH-1:0];
                if (w_inc) state_d = ST_ALU_HI;
            end
            ST_ALU_HI: begin
                wr_data = hold_q[2*WIDTH-1:WIDTH];
                if (w_inc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_inc) cnt_d = cnt_q + BYTE_CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            rf_ack_q  <= 1'b0;
            alu_ack_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rf_ack_q  <= rf_ack_d;
            alu_ack_q <= alu_ack_d;
            cnt_q     <= cnt_d;
        end
    end

    assign RF_ACK   = rf_ack_q;
    assign ALU_ACK  = alu_ack_q;
    assign W_INC    = w_inc;
    assign WR_DATA  = wr_data;
    assign BYTE_CNT = cnt_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_sched.sv
// tb_fifo_wr_sched -- directed self-checking bench for fifo_wr_sched.
// Rev 1.0
`default_nettype none

module tb_fifo_wr_sched;

    logic        CLK;
    logic        RST;
    logic        RF_REQ;
    logic [7:0]  RF_DATA;
    logic        ALU_REQ;
    logic [15:0] ALU_DATA;
    logic        FULL;
    logic        RF_ACK;
    logic        ALU_ACK;
    logic        W_INC;
    logic [7:0]  WR_DATA;
    logic [7:0]  BYTE_CNT;
    logic        BUSY;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          alu_acks = 0;
    logic [7:0]  exp_cnt;
    logic [7:0]  wr_log[$];

    fifo_wr_sched #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RF_REQ   (RF_REQ),
        .RF_DATA  (RF_DATA),
        .ALU_REQ  (ALU_REQ),
        .ALU_DATA (ALU_DATA),
        .FULL     (FULL),
        .RF_ACK   (RF_ACK),
        .ALU_ACK  (ALU_ACK),
        .W_INC    (W_INC),
        .WR_DATA  (WR_DATA),
        .BYTE_CNT (BYTE_CNT),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Every byte written to the FIFO, in order, sampled mid-cycle.
    always @(negedge CLK) begin
        if (W_INC === 1'b1) wr_log.push_back(WR_DATA);
        if (ALU_ACK === 1'b1) alu_acks++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end

    task automatic apply_reset();
        RST = 1'b0; RF_REQ = 1'b0; ALU_REQ = 1'b0; FULL = 1'b0;
        RF_DATA = '0; ALU_DATA = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset();
        RST = 1'b0; RF_REQ = 1'b1; ALU_REQ = 1'b1; FULL = 1'b0;
        RF_DATA = 8'hFF; ALU_DATA = 16'hFFFF;
        @(negedge CLK);
        n_checks++;
        if ({RF_ACK, ALU_ACK, W_INC, BUSY} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got ack_rf/ack_alu/winc/busy=%b, expected 0000",
                     {RF_ACK, ALU_ACK, W_INC, BUSY});
        end
        n_checks++;
        if (WR_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wr_data: got %02h, expected 00", WR_DATA);
        end
        n_checks++;
        if (BYTE_CNT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_byte_cnt: got %0d, expected 0", BYTE_CNT);
        end
        apply_reset();
    endtask

    task automatic test_rf_single();
        RF_REQ = 1'b1; RF_DATA = 8'h5A;
        @(negedge CLK);
        n_checks++;
        if ({RF_ACK, W_INC, BUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL rf_idle: got ack/winc/busy=%b, expected 000", {RF_ACK, W_INC, BUSY});
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if ({RF_ACK, W_INC, BUSY, WR_DATA} !== {3'b111, 8'h5A}) begin
            n_fail++;
            $display("FAIL rf_cycle1: got ack/winc/busy=%b data=%02h, expected 111 5a",
                     {RF_ACK, W_INC, BUSY}, WR_DATA);
        end
        @(posedge CLK); #1;
        RF_REQ = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        @(negedge CLK);
        n_checks++;
        if ({RF_ACK, W_INC, BUSY, BYTE_CNT} !== {3'b000, exp_cnt}) begin
            n_fail++;
            $display("FAIL rf_done: got ack/winc/busy=%b cnt=%0d, expected 000 %0d",
                     {RF_ACK, W_INC, BUSY}, BYTE_CNT, exp_cnt);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_alu_split();
        int acks0;
        acks0 = alu_acks;
        ALU_REQ = 1'b1; ALU_DATA = 16'hBEEF;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if ({ALU_ACK, W_INC, WR_DATA} !== {2'b11, 8'hEF}) begin
            n_fail++;
            $display("FAIL alu_lo: got ack/winc=%b data=%02h, expected 11 ef",
                     {ALU_ACK, W_INC}, WR_DATA);
        end
        @(posedge CLK); #1;
        ALU_REQ = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({ALU_ACK, W_INC, WR_DATA} !== {2'b01, 8'hBE}) begin
            n_fail++;
            $display("FAIL alu_hi: got ack/winc=%b data=%02h, expected 01 be",
                     {ALU_ACK, W_INC}, WR_DATA);
        end
        @(posedge CLK); #1;
        exp_cnt = exp_cnt + 8'd2;
        @(negedge CLK);
        n_checks++;
        if ({W_INC, BUSY, BYTE_CNT} !== {2'b00, exp_cnt}) begin
            n_fail++;
            $display("FAIL alu_done: got winc/busy=%b cnt=%0d, expected 00 %0d",
                     {W_INC, BUSY}, BYTE_CNT, exp_cnt);
        end
        n_checks++;
        if (alu_acks - acks0 != 1) begin
            n_fail++;
            $display("FAIL alu_ack_count: got %0d pulses, expected 1", alu_acks - acks0);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_seq [6];
        logic [7:0] rf_d    [2];
        logic [15:0] alu_d  [2];
        exp_seq = '{8'h11, 8'hBB, 8'hAA, 8'h22, 8'hDD, 8'hCC};
        rf_d    = '{8'h11, 8'h22};
        alu_d   = '{16'hAABB, 16'hCCDD};
        apply_reset();
        wr_log.delete();
        fork
            begin
                bit got;
                for (int k = 0; k < 2; k++) begin
                    RF_DATA = rf_d[k]; RF_REQ = 1'b1; got = 1'b0;
                    for (int c = 0; c < 20 && !got; c++) begin
                        @(negedge CLK);
                        if (RF_ACK === 1'b1) got = 1'b1;
                        @(posedge CLK); #1;
                    end
                    RF_REQ = 1'b0;
                    n_checks++;
                    if (!got) begin
                        n_fail++;
                        $display("FAIL b2b_rf_ack_timeout: got no ack for item %0d, expected ack within 20 cycles", k);
                    end
                end
            end
            begin
                bit got;
                for (int k = 0; k < 2; k++) begin
                    ALU_DATA = alu_d[k]; ALU_REQ = 1'b1; got = 1'b0;
                    for (int c = 0; c < 20 && !got; c++) begin
                        @(negedge CLK);
                        if (ALU_ACK === 1'b1) got = 1'b1;
                        @(posedge CLK); #1;
                    end
                    ALU_REQ = 1'b0;
                    n_checks++;
                    if (!got) begin
                        n_fail++;
                        $display("FAIL b2b_alu_ack_timeout: got no ack for item %0d, expected ack within 20 cycles", k);
                    end
                end
            end
        join
        repeat (3) begin @(posedge CLK); #1; end
        n_checks++;
        if (wr_log.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bytes, expected 6", wr_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (wr_log[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got %02h, expected %02h", i, wr_log[i], exp_seq[i]);
                end
            end
        end
        exp_cnt = 8'd6;
    endtask

    task automatic test_backpressure();
        int bad;
        ALU_REQ = 1'b1; ALU_DATA = 16'h1234;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if ({W_INC, WR_DATA} !== {1'b1, 8'h34}) begin
            n_fail++;
            $display("FAIL bp_lo: got winc=%b data=%02h, expected 1 34", W_INC, WR_DATA);
        end
        @(posedge CLK); #1;
        ALU_REQ = 1'b0; FULL = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if ({W_INC, BUSY, WR_DATA, BYTE_CNT} !== {2'b01, 8'h12, exp_cnt}) bad++;
            @(posedge CLK); #1;
            if (i == 4) FULL = 1'b0;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad cycles while full, expected 0", bad);
        end
        @(negedge CLK);
        n_checks++;
        if ({W_INC, WR_DATA} !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL bp_release: got winc=%b data=%02h, expected 1 12", W_INC, WR_DATA);
        end
        @(posedge CLK); #1;
        exp_cnt = exp_cnt + 8'd1;
        @(negedge CLK);
        n_checks++;
        if ({BUSY, BYTE_CNT} !== {1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL bp_done: got busy=%b cnt=%0d, expected 0 %0d", BUSY, BYTE_CNT, exp_cnt);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int log0;
        int acks0;
        ALU_REQ = 1'b1; ALU_DATA = 16'hA5C3;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++;
        if ({W_INC, WR_DATA} !== {1'b1, 8'hC3}) begin
            n_fail++;
            $display("FAIL rm_lo: got winc=%b data=%02h, expected 1 c3", W_INC, WR_DATA);
        end
        @(posedge CLK); #1;
        ALU_REQ = 1'b0;
        #2;
        log0  = wr_log.size();
        acks0 = alu_acks;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({RF_ACK, ALU_ACK, W_INC, BUSY, WR_DATA, BYTE_CNT} !== {4'b0000, 8'h00, 8'h00}) begin
            n_fail++;
            $display("FAIL rm_async: got flags=%b data=%02h cnt=%0d, expected 0000 00 0",
                     {RF_ACK, ALU_ACK, W_INC, BUSY}, WR_DATA, BYTE_CNT);
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_cnt = 8'd0;
        repeat (4) begin @(posedge CLK); #1; end
        n_checks++;
        if (wr_log.size() != log0 || alu_acks != acks0 || BYTE_CNT !== 8'h00) begin
            n_fail++;
            $display("FAIL rm_discard: got %0d extra bytes, %0d extra acks, cnt=%0d, expected 0 0 0",
                     wr_log.size() - log0, alu_acks - acks0, BYTE_CNT);
        end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        RF_REQ = 1'b1; RF_DATA = 8'h3C;
        for (int c = 0; c < 510; c++) begin
            @(negedge CLK);
            if (W_INC !== ((c % 2) == 1)) bad++;
            @(posedge CLK); #1;
        end
        RF_REQ = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (bad != 0 || BYTE_CNT !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255: got %0d bad strobes cnt=%0d, expected 0 255", bad, BYTE_CNT);
        end
        @(posedge CLK); #1;
        RF_REQ = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        @(posedge CLK); #1;
        RF_REQ = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (BYTE_CNT !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got cnt=%0d, expected 0", BYTE_CNT);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_rf_single();
        test_alu_split();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
